// File: rtl/riscv_checkpoint_monitor_if.sv
// Signal bundle between a RISC-V core harness and the checkpoint monitor:
// table load, core observation and verdict.
interface riscv_checkpoint_monitor_if #(
    parameter int unsigned IDW = 6
);
    logic            START;
    logic            CHK_WE;
    logic [IDW-1:0]  CHK_WADDR;
    logic [31:0]     CHK_WNUM;
    logic [31:0]     CHK_WANS;
    logic [31:0]     NUM_INST;
    logic [31:0]     OUTPUT_PORT;
    logic            HALT;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic            FAIL;
    logic [1:0]      FAIL_CODE;
    logic [IDW-1:0]  FAIL_IDX;
    logic [31:0]     FAIL_GOT;
    logic [IDW:0]    PASS_CNT;
    logic [31:0]     CYCLE_CNT;

    modport master (
        output START, CHK_WE, CHK_WADDR, CHK_WNUM, CHK_WANS, NUM_INST, OUTPUT_PORT, HALT,
        input  BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_GOT, PASS_CNT, CYCLE_CNT
    );

    modport slave (
        input  START, CHK_WE, CHK_WADDR, CHK_WNUM, CHK_WANS, NUM_INST, OUTPUT_PORT, HALT,
        output BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_GOT, PASS_CNT, CYCLE_CNT
    );
endinterface

// File: rtl/riscv_checkpoint_monitor.sv
// Walks an ascending (instruction-count, expected-output) table against a running core
// and latches a sticky PASS/FAIL verdict with cause, index, offending value and cycle count.
module riscv_checkpoint_monitor #(
    parameter int unsigned NUM_CHK = 40,
    parameter int unsigned IDW     = 6,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    riscv_checkpoint_monitor_if.slave  mon
);
    localparam int unsigned AW = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
    localparam logic [IDW-1:0] LAST_PTR = IDW'(NUM_CHK);
    localparam logic [31:0]    TMO      = 32'(TIMEOUT);
    localparam logic [1:0] FC_TIMEOUT  = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_SKIPPED  = 2'b10;
    localparam logic [1:0] FC_INCOMPL  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [31:0]    cyc_q, cyc_d;
    logic [1:0]     fcode_q, fcode_d;
    logic [IDW-1:0] fidx_q, fidx_d;
    logic [31:0]    fgot_q, fgot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           fail_q, fail_d;

    logic [31:0] tbl_num_q [NUM_CHK];
    logic [31:0] tbl_ans_q [NUM_CHK];

    logic        ptr_valid;
    logic [31:0] e_num, e_ans;
    logic [31:0] cyc_inc;
    logic [IDW-1:0] ptr_nxt;
    logic        chk_fail;

    // Table storage is intentionally not reset so it survives RSTn between runs.
    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && mon.CHK_WE && mon.CHK_WADDR < LAST_PTR) begin
            tbl_num_q[AW'(mon.CHK_WADDR)] <= mon.CHK_WNUM;
            tbl_ans_q[AW'(mon.CHK_WADDR)] <= mon.CHK_WANS;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cyc_q   <= '0;
            fcode_q <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cyc_q   <= cyc_d;
            fcode_q <= fcode_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cyc_d    = cyc_q;
        fcode_d  = fcode_q;
        fidx_d   = fidx_q;
        fgot_d   = fgot_q;
        ptr_nxt  = ptr_q;
        chk_fail = 1'b0;
        ptr_valid = (ptr_q < LAST_PTR);
        e_num    = ptr_valid ? tbl_num_q[AW'(ptr_q)] : '0;
        e_ans    = ptr_valid ? tbl_ans_q[AW'(ptr_q)] : '0;
        cyc_inc  = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

        unique case (state_q)
            S_IDLE: begin
                if (mon.START) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    cyc_d   = '0;
                end
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                if (ptr_valid && mon.NUM_INST == e_num) begin
                    if (mon.OUTPUT_PORT == e_ans) begin
                        ptr_nxt = ptr_q + IDW'(1);
                    end else begin
                        chk_fail = 1'b1;
                        fcode_d  = FC_MISMATCH;
                        fgot_d   = mon.OUTPUT_PORT;
                    end
                end else if (ptr_valid && mon.NUM_INST > e_num) begin
                    chk_fail = 1'b1;
                    fcode_d  = FC_SKIPPED;
                    fgot_d   = mon.NUM_INST;
                end
                ptr_d = ptr_nxt;
                // A match in the HALT cycle still counts toward completion.
                if (chk_fail) begin
                    state_d = S_FAIL;
                    fidx_d  = ptr_q;
                end else if (mon.HALT) begin
                    if (ptr_nxt == LAST_PTR) begin
                        state_d = S_PASS;
                    end else begin
                        state_d = S_FAIL;
                        fcode_d = FC_INCOMPL;
                        fidx_d  = ptr_nxt;
                        fgot_d  = mon.NUM_INST;
                    end
                end else if (cyc_inc >= TMO) begin
                    state_d = S_FAIL;
                    fcode_d = FC_TIMEOUT;
                    fidx_d  = ptr_nxt;
                    fgot_d  = mon.NUM_INST;
                end
            end
            default: ;
        endcase

        busy_d = (state_d == S_RUN);
        pass_d = (state_d == S_PASS);
        fail_d = (state_d == S_FAIL);
        done_d = pass_d | fail_d;
    end

    assign mon.BUSY      = busy_q;
    assign mon.DONE      = done_q;
    assign mon.PASS      = pass_q;
    assign mon.FAIL      = fail_q;
    assign mon.FAIL_CODE = fail_q ? fcode_q : 2'b00;
    assign mon.FAIL_IDX  = fail_q ? fidx_q : '0;
    assign mon.FAIL_GOT  = fail_q ? fgot_q : '0;
    assign mon.PASS_CNT  = {1'b0, ptr_q};
    assign mon.CYCLE_CNT = cyc_q;
endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Directed bench for riscv_checkpoint_monitor: 3-entry table, pass, mismatch, skip,
// incomplete, timeout with ignored table write, and mid-run reset.
module tb_riscv_checkpoint_monitor;
    localparam int unsigned NUM_CHK = 3;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 50;

    logic CLK = 1'b0;
    logic RSTn;
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_checkpoint_monitor_if #(.IDW(IDW)) mon ();

    riscv_checkpoint_monitor #(.NUM_CHK(NUM_CHK), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .mon (mon)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
    endtask

    task automatic wr(input logic [IDW-1:0] a, input logic [31:0] n, input logic [31:0] v);
        mon.CHK_WE = 1'b1; mon.CHK_WADDR = a; mon.CHK_WNUM = n; mon.CHK_WANS = v;
        tick();
        mon.CHK_WE = 1'b0;
    endtask

    task automatic start();
        mon.START = 1'b1;
        tick();
        mon.START = 1'b0;
    endtask

    task automatic step(input logic [31:0] n, input logic [31:0] o, input logic h);
        mon.NUM_INST = n; mon.OUTPUT_PORT = o; mon.HALT = h;
        tick();
        mon.HALT = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(mon.BUSY), 32'd0);
        chk({tag, "_done"}, 32'(mon.DONE), 32'd0);
        chk({tag, "_pass"}, 32'(mon.PASS), 32'd0);
        chk({tag, "_fail"}, 32'(mon.FAIL), 32'd0);
        chk({tag, "_pcnt"}, 32'(mon.PASS_CNT), 32'd0);
        chk({tag, "_cyc"},  mon.CYCLE_CNT, 32'd0);
    endtask

    // Passing run of the reference table: 4 steps, HALT at NUM_INST=9.
    task automatic run_pass(input string tag);
        start();
        chk({tag, "_busy"}, 32'(mon.BUSY), 32'd1);
        step(32'd4, 32'hF00, 1'b0);
        step(32'd6, 32'h18, 1'b0);
        step(32'd8, 32'h1D, 1'b0);
        step(32'd9, 32'h1D, 1'b1);
        chk({tag, "_pass"}, 32'(mon.PASS), 32'd1);
        chk({tag, "_fail"}, 32'(mon.FAIL), 32'd0);
        chk({tag, "_done"}, 32'(mon.DONE), 32'd1);
        chk({tag, "_pcnt"}, 32'(mon.PASS_CNT), 32'd3);
        chk({tag, "_cyc"},  mon.CYCLE_CNT, 32'd4);
    endtask

    initial begin
        RSTn = 1'b0;
        mon.START = 1'b0; mon.CHK_WE = 1'b0; mon.CHK_WADDR = '0;
        mon.CHK_WNUM = '0; mon.CHK_WANS = '0;
        mon.NUM_INST = '0; mon.OUTPUT_PORT = '0; mon.HALT = 1'b0;
        tick(); tick();
        RSTn = 1'b1;
        check_idle("rst");

        wr(2'd0, 32'd4, 32'hF00);
        wr(2'd1, 32'd6, 32'h18);
        wr(2'd2, 32'd8, 32'h1D);
        wr(2'd3, 32'd5, 32'h0);      // out-of-range index, dropped

        // 1: full pass
        run_pass("t1");
        start();                     // ignored in terminal state
        chk("t1_sticky", 32'(mon.PASS), 32'd1);

        // 2: mismatch at entry 1
        do_reset();
        start();
        step(32'd4, 32'hF00, 1'b0);
        step(32'd6, 32'h19, 1'b0);
        chk("t2_fail", 32'(mon.FAIL), 32'd1);
        chk("t2_code", 32'(mon.FAIL_CODE), 32'd1);
        chk("t2_idx",  32'(mon.FAIL_IDX), 32'd1);
        chk("t2_got",  mon.FAIL_GOT, 32'h19);
        chk("t2_pass", 32'(mon.PASS), 32'd0);

        // 3: entry 1 skipped
        do_reset();
        start();
        step(32'd4, 32'hF00, 1'b0);
        step(32'd5, 32'hF00, 1'b0);
        chk("t3_busy", 32'(mon.BUSY), 32'd1);
        step(32'd7, 32'hF00, 1'b0);
        chk("t3_fail", 32'(mon.FAIL), 32'd1);
        chk("t3_code", 32'(mon.FAIL_CODE), 32'd2);
        chk("t3_idx",  32'(mon.FAIL_IDX), 32'd1);
        chk("t3_got",  mon.FAIL_GOT, 32'd7);

        // 4: HALT together with match on entry 1, entry 2 pending
        do_reset();
        start();
        step(32'd4, 32'hF00, 1'b0);
        step(32'd6, 32'h18, 1'b1);
        chk("t4_fail", 32'(mon.FAIL), 32'd1);
        chk("t4_code", 32'(mon.FAIL_CODE), 32'd3);
        chk("t4_idx",  32'(mon.FAIL_IDX), 32'd2);
        chk("t4_pcnt", 32'(mon.PASS_CNT), 32'd2);

        // 5: timeout; a table write during RUN must be ignored
        do_reset();
        start();
        mon.NUM_INST = 32'd0; mon.OUTPUT_PORT = 32'd0;
        wr(2'd0, 32'd1, 32'h0);
        for (int i = 0; i < 60 && !mon.DONE; i++) tick();
        chk("t5_done", 32'(mon.DONE), 32'd1);
        chk("t5_code", 32'(mon.FAIL_CODE), 32'd0);
        chk("t5_fail", 32'(mon.FAIL), 32'd1);
        chk("t5_cyc",  mon.CYCLE_CNT, 32'd50);
        chk("t5_idx",  32'(mon.FAIL_IDX), 32'd0);
        do_reset();
        run_pass("t5_rerun");

        // 6: reset mid-run clears everything, table retained
        do_reset();
        start();
        step(32'd4, 32'hF00, 1'b0);
        chk("t6_pcnt_pre", 32'(mon.PASS_CNT), 32'd1);
        do_reset();
        check_idle("t6_rst");
        run_pass("t6_rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
